rf_write_sequencer: RTL

- Writer-side front end for the 16x16 register file write port.
- Accepts write-back requests (address, data) from execution units over a valid/ready handshake and buffers them in a small in-order queue.
- The register file commits on the rising edge of its write-enable, so this block drives a clean setup/strobe/release sequence on that port.
- Offers a bypass lookup so operand readers see values still pending in the queue.

---
 rtl/rf_write_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/rf_write_sequencer.sv
// In-order write-back queue driving a setup/strobe/release write sequence
// into the register file. Optional bypass lookup enabled by RF_BYPASS_EN.
module rf_write_sequencer #(
  parameter int N     = 16,
  parameter int M     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [M-1:0]             inAddr,
  input  logic [N-1:0]             inData,
  output logic                     rfWriteEnable,
  output logic [M-1:0]             rfWriteAddr,
  output logic [N-1:0]             rfDIn,
  input  logic [M-1:0]             lookupAddr0,
  input  logic [M-1:0]             lookupAddr1,
  output logic                     hit0,
  output logic                     hit1,
  output logic [N-1:0]             hitData0,
  output logic [N-1:0]             hitData1,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RELEASE
  } state_e;

  state_e          state_q, state_d;

  logic [M-1:0]    addr_mem_q [DEPTH];
  logic [M-1:0]    addr_mem_d [DEPTH];
  logic [N-1:0]    data_mem_q [DEPTH];
  logic [N-1:0]    data_mem_d [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            we_q, we_d;
  logic [M-1:0]    waddr_q, waddr_d;
  logic [N-1:0]    wdata_q, wdata_d;

  logic            push;
  logic            pop;
  logic [PW-1:0]   next_head;
  logic            more_left;

  assign inReady   = (count_q != CW'(DEPTH));
  assign push      = inValid && inReady;
  assign pop       = (state_q == S_RELEASE);
  assign next_head = rd_ptr_q + PW'(1);
  assign more_left = (count_q > CW'(1));

  assign rfWriteEnable = we_q;
  assign rfWriteAddr   = waddr_q;
  assign rfDIn         = wdata_q;
  assign count         = count_q;
  assign idle          = (count_q == '0) && (state_q == S_IDLE);

  // Queue storage, pointers and occupancy update.
  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      addr_mem_d[wr_ptr_q] = inAddr;
      data_mem_d[wr_ptr_q] = inData;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = next_head;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue register bank; discarded on reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= addr_mem_d[i];
        data_mem_q[i] <= data_mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write-sequence state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write-sequence next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_SETUP;
        end
      end
      S_SETUP:   state_d = S_STROBE;
      S_STROBE:  state_d = S_RELEASE;
      S_RELEASE: state_d = more_left ? S_SETUP : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Register-file port values; address/data held outside load points.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          waddr_d = addr_mem_q[rd_ptr_q];
          wdata_d = data_mem_q[rd_ptr_q];
        end
      end
      S_SETUP:  we_d = 1'b1;
      S_STROBE: we_d = 1'b0;
      S_RELEASE: begin
        if (more_left) begin
          waddr_d = addr_mem_q[next_head];
          wdata_d = data_mem_q[next_head];
        end
      end
      default: we_d = 1'b0;
    endcase
  end

  // Registered register-file port; enable drops at once on reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef RF_BYPASS_EN
  logic [PW-1:0] idx;

  // Bypass: scan oldest to newest so the newest match wins.
  always_comb begin
    hit0     = 1'b0;
    hit1     = 1'b0;
    hitData0 = '0;
    hitData1 = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (addr_mem_q[idx] == lookupAddr0) begin
          hit0     = 1'b1;
          hitData0 = data_mem_q[idx];
        end
        if (addr_mem_q[idx] == lookupAddr1) begin
          hit1     = 1'b1;
          hitData1 = data_mem_q[idx];
        end
      end
    end
  end
`else
  logic unused_lookup;

  assign unused_lookup = ^{lookupAddr0, lookupAddr1};
  assign hit0          = 1'b0;
  assign hit1          = 1'b0;
  assign hitData0      = '0;
  assign hitData1      = '0;
`endif

endmodule
